// File: rtl/arithmetic_rs_if.sv
// Dispatch, result-broadcast and issue signals of the arithmetic reservation station.
// The master side dispatches instructions and broadcasts results; the slave side is the station.
interface arithmetic_rs_if #(
   parameter int XLEN     = 32,
   parameter int ROB_SIZE = 256
);
   localparam int TW = $clog2(ROB_SIZE);

   // dispatch
   logic            disp_valid;
   logic            disp_ready;
   logic            disp_additional_info;
   logic [2:0]      disp_arith_type;
   logic [TW-1:0]   disp_rob_entry;
   logic            disp_rs1_rdy;
   logic            disp_rs2_rdy;
   logic [XLEN-1:0] disp_rs1_val;
   logic [XLEN-1:0] disp_rs2_val;
   logic [TW-1:0]   disp_rs1_tag;
   logic [TW-1:0]   disp_rs2_tag;

   // common data bus
   logic            cdb_valid;
   logic [TW-1:0]   cdb_rob_entry;
   logic [XLEN-1:0] cdb_result;

   // functional-unit issue
   logic            issue_valid;
   logic            issue_additional_info;
   logic [2:0]      issue_arith_type;
   logic [TW-1:0]   issue_rob_entry;
   logic [XLEN-1:0] issue_rs1;
   logic [XLEN-1:0] issue_rs2;

   modport master (
      output disp_valid, disp_additional_info, disp_arith_type, disp_rob_entry,
             disp_rs1_rdy, disp_rs2_rdy, disp_rs1_val, disp_rs2_val,
             disp_rs1_tag, disp_rs2_tag,
             cdb_valid, cdb_rob_entry, cdb_result,
      input  disp_ready,
             issue_valid, issue_additional_info, issue_arith_type,
             issue_rob_entry, issue_rs1, issue_rs2
   );

   modport slave (
      input  disp_valid, disp_additional_info, disp_arith_type, disp_rob_entry,
             disp_rs1_rdy, disp_rs2_rdy, disp_rs1_val, disp_rs2_val,
             disp_rs1_tag, disp_rs2_tag,
             cdb_valid, cdb_rob_entry, cdb_result,
      output disp_ready,
             issue_valid, issue_additional_info, issue_arith_type,
             issue_rob_entry, issue_rs1, issue_rs2
   );
endinterface

// File: rtl/arithmetic_rs.sv
// Arithmetic reservation station: holds dispatched instructions until both
// operands are available (directly, by CDB wakeup or by dispatch-time bypass),
// then issues the lowest-index ready entry to the functional unit, one per cycle.
module arithmetic_rs #(
   parameter int XLEN     = 32,
   parameter int ROB_SIZE = 256,
   parameter int RS_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   arithmetic_rs_if.slave bus
);
   localparam int TW = $clog2(ROB_SIZE);
   localparam int IW = $clog2(RS_DEPTH);

   typedef struct packed {
      logic            valid;
      logic            info;
      logic [2:0]      arith_type;
      logic [TW-1:0]   rob;
      logic            rs1_rdy;
      logic [TW-1:0]   rs1_tag;
      logic [XLEN-1:0] rs1_val;
      logic            rs2_rdy;
      logic [TW-1:0]   rs2_tag;
      logic [XLEN-1:0] rs2_val;
   } entry_t;

   // Fields that travel to the functional unit on issue.
   typedef struct packed {
      logic            info;
      logic [2:0]      arith_type;
      logic [TW-1:0]   rob;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
   } pay_t;

   logic [RS_DEPTH-1:0] free_vec;
   logic [RS_DEPTH-1:0] elig_vec;
   logic [RS_DEPTH-1:0] disp_sel;
   pay_t                pay [RS_DEPTH];
   logic [IW-1:0]       iss_idx;
   logic                found_free;
   logic                found_elig;
   logic                any_free;
   logic                any_elig;
   logic                disp_ready_int;
   logic                disp_fire;
   logic                rs1_byp;
   logic                rs2_byp;
   entry_t              disp_entry;

   logic                issue_valid_reg;
   pay_t                iss_pay_reg;

   // Freedom and eligibility are judged on the registered state, so entries
   // freed or woken this cycle only count from the next cycle on.
   assign any_free       = |free_vec;
   assign any_elig       = |elig_vec;
   assign disp_ready_int = any_free & ~flush;
   assign disp_fire      = bus.disp_valid & disp_ready_int;
   assign bus.disp_ready = disp_ready_int;

   // A source still waiting at dispatch can catch a result broadcast in the same cycle.
   assign rs1_byp = ~bus.disp_rs1_rdy & bus.cdb_valid & (bus.disp_rs1_tag == bus.cdb_rob_entry);
   assign rs2_byp = ~bus.disp_rs2_rdy & bus.cdb_valid & (bus.disp_rs2_tag == bus.cdb_rob_entry);

   // Build the entry image written on dispatch, folding in the bypass.
   always_comb begin
      disp_entry            = '0;
      disp_entry.valid      = 1'b1;
      disp_entry.info       = bus.disp_additional_info;
      disp_entry.arith_type = bus.disp_arith_type;
      disp_entry.rob        = bus.disp_rob_entry;
      disp_entry.rs1_rdy    = bus.disp_rs1_rdy | rs1_byp;
      disp_entry.rs1_tag    = bus.disp_rs1_tag;
      disp_entry.rs1_val    = rs1_byp ? bus.cdb_result : bus.disp_rs1_val;
      disp_entry.rs2_rdy    = bus.disp_rs2_rdy | rs2_byp;
      disp_entry.rs2_tag    = bus.disp_rs2_tag;
      disp_entry.rs2_val    = rs2_byp ? bus.cdb_result : bus.disp_rs2_val;
   end

   // Priority encoders: lowest free slot takes the dispatch, lowest eligible slot issues.
   always_comb begin
      disp_sel   = '0;
      iss_idx    = '0;
      found_free = 1'b0;
      found_elig = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (free_vec[i] && !found_free) begin
            disp_sel[i] = 1'b1;
            found_free  = 1'b1;
         end
         if (elig_vec[i] && !found_elig) begin
            iss_idx    = IW'(i);
            found_elig = 1'b1;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
         entry_t ent_reg;
         logic   iss_hit;
         logic   wake1;
         logic   wake2;

         assign iss_hit = any_elig && (iss_idx == IW'(gi));
         assign wake1   = bus.cdb_valid && ent_reg.valid && !ent_reg.rs1_rdy &&
                          (ent_reg.rs1_tag == bus.cdb_rob_entry);
         assign wake2   = bus.cdb_valid && ent_reg.valid && !ent_reg.rs2_rdy &&
                          (ent_reg.rs2_tag == bus.cdb_rob_entry);

         assign free_vec[gi] = ~ent_reg.valid;
         assign elig_vec[gi] = ent_reg.valid & ent_reg.rs1_rdy & ent_reg.rs2_rdy;
         assign pay[gi]      = '{info:       ent_reg.info,
                                 arith_type: ent_reg.arith_type,
                                 rob:        ent_reg.rob,
                                 rs1:        ent_reg.rs1_val,
                                 rs2:        ent_reg.rs2_val};

         // Entry state: flush beats everything; a free slot may be filled, an occupied one issued or woken.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               ent_reg <= '0;
            end else if (flush) begin
               ent_reg.valid <= 1'b0;
            end else if (disp_fire && disp_sel[gi]) begin
               ent_reg <= disp_entry;
            end else begin
               if (iss_hit) begin
                  ent_reg.valid <= 1'b0;
               end
               if (wake1) begin
                  ent_reg.rs1_rdy <= 1'b1;
                  ent_reg.rs1_val <= bus.cdb_result;
               end
               if (wake2) begin
                  ent_reg.rs2_rdy <= 1'b1;
                  ent_reg.rs2_val <= bus.cdb_result;
               end
            end
         end
      end
   endgenerate

   // Issue register: pulses valid for one cycle per issued entry; data holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issue_valid_reg <= 1'b0;
         iss_pay_reg     <= '0;
      end else if (flush) begin
         issue_valid_reg <= 1'b0;
      end else begin
         issue_valid_reg <= any_elig;
         if (any_elig) begin
            iss_pay_reg <= pay[iss_idx];
         end
      end
   end

   assign bus.issue_valid           = issue_valid_reg;
   assign bus.issue_additional_info = iss_pay_reg.info;
   assign bus.issue_arith_type      = iss_pay_reg.arith_type;
   assign bus.issue_rob_entry       = iss_pay_reg.rob;
   assign bus.issue_rs1             = iss_pay_reg.rs1;
   assign bus.issue_rs2             = iss_pay_reg.rs2;
endmodule

// File: tb/tb_arithmetic_rs.sv
// Bench for arithmetic_rs: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a slot-array reference model.
module tb_arithmetic_rs;
   localparam int XLEN     = 32;
   localparam int ROB_SIZE = 256;
   localparam int RS_DEPTH = 4;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic flush = 1'b0;

   arithmetic_rs_if #(.XLEN(XLEN), .ROB_SIZE(ROB_SIZE)) bus();

   arithmetic_rs #(.XLEN(XLEN), .ROB_SIZE(ROB_SIZE), .RS_DEPTH(RS_DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   // Reference model: what each station slot holds, as plain records.
   typedef struct {
      bit        valid;
      bit        info;
      bit [2:0]  typ;
      bit [7:0]  rob;
      bit        r1;
      bit [7:0]  t1;
      bit [31:0] v1;
      bit        r2;
      bit [7:0]  t2;
      bit [31:0] v2;
   } ment_t;

   ment_t     m [RS_DEPTH];
   bit        exp_iv;
   bit        exp_info;
   bit [2:0]  exp_typ;
   bit [7:0]  exp_rob;
   bit [31:0] exp_rs1;
   bit [31:0] exp_rs2;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_has_free();
      for (int i = 0; i < RS_DEPTH; i++)
         if (!m[i].valid) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < RS_DEPTH; i++) m[i] = '{default: 0};
      exp_iv = 0; exp_info = 0; exp_typ = 0; exp_rob = 0; exp_rs1 = 0; exp_rs2 = 0;
   endtask

   // One clock edge of the station described by its rules: pick, wake, then accept.
   task automatic model_step();
      int    sel;
      int    fr;
      ment_t n;
      if (flush) begin
         for (int i = 0; i < RS_DEPTH; i++) m[i].valid = 0;
         exp_iv = 0;
         return;
      end
      sel = -1;
      fr  = -1;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (m[i].valid && m[i].r1 && m[i].r2 && sel < 0) sel = i;
         if (!m[i].valid && fr < 0) fr = i;
      end
      if (sel >= 0) begin
         exp_iv   = 1;
         exp_info = m[sel].info;
         exp_typ  = m[sel].typ;
         exp_rob  = m[sel].rob;
         exp_rs1  = m[sel].v1;
         exp_rs2  = m[sel].v2;
         m[sel].valid = 0;
      end else begin
         exp_iv = 0;
      end
      if (bus.cdb_valid) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (m[i].valid && !m[i].r1 && m[i].t1 == bus.cdb_rob_entry) begin
               m[i].r1 = 1; m[i].v1 = bus.cdb_result;
            end
            if (m[i].valid && !m[i].r2 && m[i].t2 == bus.cdb_rob_entry) begin
               m[i].r2 = 1; m[i].v2 = bus.cdb_result;
            end
         end
      end
      if (bus.disp_valid && fr >= 0) begin
         n.valid = 1;
         n.info  = bus.disp_additional_info;
         n.typ   = bus.disp_arith_type;
         n.rob   = bus.disp_rob_entry;
         n.t1    = bus.disp_rs1_tag;
         n.t2    = bus.disp_rs2_tag;
         n.r1    = bus.disp_rs1_rdy;
         n.v1    = bus.disp_rs1_val;
         n.r2    = bus.disp_rs2_rdy;
         n.v2    = bus.disp_rs2_val;
         if (!n.r1 && bus.cdb_valid && n.t1 == bus.cdb_rob_entry) begin
            n.r1 = 1; n.v1 = bus.cdb_result;
         end
         if (!n.r2 && bus.cdb_valid && n.t2 == bus.cdb_rob_entry) begin
            n.r2 = 1; n.v2 = bus.cdb_result;
         end
         m[fr] = n;
      end
   endtask

   // Advance the model on the same events that move the station.
   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else      model_step();
   end

   // Compare process: DUT outputs against the model, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         chk("issue_valid", bus.issue_valid, exp_iv);
         chk("disp_ready", bus.disp_ready, model_has_free() && !flush);
         if (exp_iv) begin
            chk("issue_rob", bus.issue_rob_entry, exp_rob);
            chk("issue_info", bus.issue_additional_info, exp_info);
            chk("issue_type", bus.issue_arith_type, exp_typ);
            chk("issue_rs1", bus.issue_rs1, exp_rs1);
            chk("issue_rs2", bus.issue_rs2, exp_rs2);
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      bus.disp_valid = 1'b0;
      bus.cdb_valid  = 1'b0;
      flush          = 1'b0;
   endtask

   task automatic disp(bit info, bit [2:0] typ, bit [7:0] rob,
                       bit r1, bit [31:0] v1, bit [7:0] t1,
                       bit r2, bit [31:0] v2, bit [7:0] t2);
      bus.disp_valid           = 1'b1;
      bus.disp_additional_info = info;
      bus.disp_arith_type      = typ;
      bus.disp_rob_entry       = rob;
      bus.disp_rs1_rdy         = r1;
      bus.disp_rs1_val         = v1;
      bus.disp_rs1_tag         = t1;
      bus.disp_rs2_rdy         = r2;
      bus.disp_rs2_val         = v2;
      bus.disp_rs2_tag         = t2;
   endtask

   task automatic cdb(bit [7:0] tag, bit [31:0] res);
      bus.cdb_valid     = 1'b1;
      bus.cdb_rob_entry = tag;
      bus.cdb_result    = res;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      idle();
      disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
      bus.disp_valid = 1'b0;
      cdb(0, 0);
      bus.cdb_valid = 1'b0;
      rst = 1'b0;
      repeat (3) cyc();
      rst = 1'b1;
      #1;
      chk("rst_disp_ready", bus.disp_ready, 1);
      chk("rst_issue_valid", bus.issue_valid, 0);
      chk("rst_issue_rs1", bus.issue_rs1, 0);
      chk("rst_issue_rob", bus.issue_rob_entry, 0);
      check_en = 1'b1;

      // Ready dispatch issues one cycle after it is written.
      disp(1, 0, 7, 1, 5, 0, 1, 3, 0);
      cyc(); idle(); cyc();
      chk("t1_valid", bus.issue_valid, 1);
      chk("t1_rs1", bus.issue_rs1, 5);
      chk("t1_rs2", bus.issue_rs2, 3);
      chk("t1_rob", bus.issue_rob_entry, 7);
      chk("t1_info", bus.issue_additional_info, 1);
      chk("t1_fu_sub", 32'(bus.issue_rs1 - bus.issue_rs2), 2);
      cyc();
      chk("t1_one_pulse", bus.issue_valid, 0);

      // Wakeup from the CDB.
      disp(0, 0, 1, 0, 0, 12, 1, 4, 0);
      cyc(); idle(); cyc();
      chk("t2_waiting", bus.issue_valid, 0);
      cdb(12, 9);
      cyc(); idle(); cyc();
      chk("t2_valid", bus.issue_valid, 1);
      chk("t2_rs1", bus.issue_rs1, 9);
      chk("t2_rs2", bus.issue_rs2, 4);
      chk("t2_rob", bus.issue_rob_entry, 1);

      // Bypass: broadcast arrives in the dispatch cycle.
      disp(0, 0, 2, 1, 1, 0, 0, 0, 30);
      cdb(30, 32'hFFFF_FFFF);
      cyc(); idle(); cyc();
      chk("t3_valid", bus.issue_valid, 1);
      chk("t3_rs2", bus.issue_rs2, 32'hFFFF_FFFF);
      chk("t3_rob", bus.issue_rob_entry, 2);
      cyc();

      // Full station drops the fifth dispatch; waking entry 2 frees a slot.
      for (int k = 0; k < 4; k++) begin
         disp(0, 0, 8'(20 + k), 0, 0, 8'(40 + k), 1, 32'(k), 0);
         cyc();
      end
      idle();
      #1;
      chk("t4_full", bus.disp_ready, 0);
      disp(0, 0, 24, 1, 1, 0, 1, 1, 0);
      cyc(); idle(); cyc();
      chk("t4_dropped", bus.issue_valid, 0);
      chk("t4_still_full", bus.disp_ready, 0);
      cdb(42, 77);
      cyc(); idle(); cyc();
      chk("t4_valid", bus.issue_valid, 1);
      chk("t4_rob", bus.issue_rob_entry, 22);
      chk("t4_rs1", bus.issue_rs1, 77);
      chk("t4_ready_again", bus.disp_ready, 1);

      // Flush with three valid entries.
      flush = 1'b1;
      cyc(); idle(); cyc();
      chk("t5_flush_iv", bus.issue_valid, 0);
      chk("t5_flush_ready", bus.disp_ready, 1);

      // Priority: entries 1 and 3 wake together, 1 goes first.
      disp(0, 0, 30, 0, 0, 50, 1, 0, 0); cyc();
      disp(0, 0, 31, 0, 0, 51, 1, 0, 0); cyc();
      disp(0, 0, 32, 0, 0, 52, 1, 0, 0); cyc();
      disp(0, 0, 33, 0, 0, 51, 1, 0, 0); cyc();
      idle();
      cdb(51, 5);
      cyc(); idle(); cyc();
      chk("t6_first_rob", bus.issue_rob_entry, 31);
      chk("t6_first_valid", bus.issue_valid, 1);
      cyc();
      chk("t6_second_rob", bus.issue_rob_entry, 33);
      chk("t6_second_valid", bus.issue_valid, 1);
      cyc();
      chk("t6_none", bus.issue_valid, 0);
      flush = 1'b1;
      cyc(); idle(); cyc();

      // Asynchronous reset between edges while issuing.
      disp(0, 0, 60, 1, 1, 0, 1, 1, 0); cyc();
      disp(0, 0, 61, 1, 2, 0, 1, 2, 0); cyc();
      idle();
      chk("t7_pre_valid", bus.issue_valid, 1);
      chk("t7_pre_rob", bus.issue_rob_entry, 60);
      #1 rst = 1'b0;
      #1;
      chk("t7_async_drop", bus.issue_valid, 0);
      chk("t7_async_data", bus.issue_rob_entry, 0);
      cyc(); cyc();
      rst = 1'b1;
      cyc();
      chk("t7_cleared", bus.issue_valid, 0);
      chk("t7_ready", bus.disp_ready, 1);

      // Randomized traffic with small tag space so wakeups and bypasses are frequent.
      for (int n = 0; n < 2000; n++) begin
         bus.disp_valid           = 1'($urandom_range(0, 1));
         bus.disp_additional_info = 1'($urandom_range(0, 1));
         bus.disp_arith_type      = 3'($urandom_range(0, 7));
         bus.disp_rob_entry       = 8'($urandom);
         bus.disp_rs1_rdy         = ($urandom_range(0, 2) != 0);
         bus.disp_rs2_rdy         = ($urandom_range(0, 2) != 0);
         bus.disp_rs1_val         = $urandom;
         bus.disp_rs2_val         = $urandom;
         bus.disp_rs1_tag         = 8'($urandom_range(0, 7));
         bus.disp_rs2_tag         = 8'($urandom_range(0, 7));
         bus.cdb_valid            = ($urandom_range(0, 2) == 0);
         bus.cdb_rob_entry        = 8'($urandom_range(0, 7));
         bus.cdb_result           = $urandom;
         flush                    = ($urandom_range(0, 63) == 0);
         cyc();
      end
      idle();
      cyc(); cyc();
      check_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
